// File: rtl/router_pkt_pkg.sv
// Shared types and helpers for the router packet transmitter.
package router_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_t;

  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
  localparam int         MAX_LEN      = 63;
  localparam int         BUF_DEPTH    = 64;
  localparam int         PTR_W        = 6;

  // Header byte layout: length in the upper six bits, destination in the lower two.
  function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: 64x8 register array with independent write and read pointers.
// The whole payload is captured here before transmission starts, because the
// router cannot tolerate a gap in pkt_valid once a packet is under way.
module router_tx_buf
  import router_pkt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr
);

  logic [7:0]       mem_reg [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;

  // Pointer update; clear rewinds both pointers for a new packet.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= wr_data;
  end

  // Read is asynchronous so a byte written on the last LOAD edge is visible at once.
  assign rd_data = mem_reg[rd_ptr_reg];
  assign wr_ptr  = wr_ptr_reg;
  assign rd_ptr  = rd_ptr_reg;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a full payload, then sends header, payload
// and parity back-to-back under busy flow control, followed by an idle gap.
module router_pkt_tx
  import router_pkt_pkg::*;
#(
  parameter int IFG   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic             cmd_bad_par,
  output logic             cmd_err,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [7:0]       pl_data,
  input  logic             busy,
  output logic             pkt_valid,
  output logic [7:0]       pkt_data,
  output logic             tx_done,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

  tx_state_t        state_reg, state_next;
  logic [1:0]       addr_reg;
  logic [5:0]       len_reg;
  logic             bad_par_reg;
  logic [7:0]       acc_reg;
  logic             pkt_valid_reg;
  logic [7:0]       pkt_data_reg;
  logic             cmd_err_reg;
  logic             tx_done_reg;
  logic [CNT_W-1:0] count_reg;
  logic [GAP_W-1:0] gap_reg;

  logic             cmd_fire, cmd_legal, pl_fire, last_load, last_payload;
  logic             buf_clear, buf_rd_en;
  logic [7:0]       buf_rd_data;
  logic [PTR_W-1:0] buf_wr_ptr, buf_rd_ptr;

  router_tx_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .wr_en   (pl_fire),
    .wr_data (pl_data),
    .rd_en   (buf_rd_en),
    .rd_data (buf_rd_data),
    .wr_ptr  (buf_wr_ptr),
    .rd_ptr  (buf_rd_ptr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake/control decode.
  always_comb begin
    state_next   = state_reg;
    cmd_ready    = 1'b0;
    pl_ready     = 1'b0;
    buf_rd_en    = 1'b0;
    cmd_legal    = (cmd_addr != ADDR_ILLEGAL) && (cmd_len != '0);
    // rd_ptr equal to len means the byte on the wire is the final payload byte.
    last_payload = (buf_rd_ptr == len_reg);
    last_load    = (buf_wr_ptr == len_reg - 6'd1);
    case (state_reg)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst && cmd_legal) state_next = LOAD;
      end
      LOAD: begin
        pl_ready = !rst;
        if (pl_valid && !rst && last_load) state_next = HEADER;
      end
      HEADER: begin
        if (!busy) begin
          buf_rd_en  = 1'b1;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (last_payload) state_next = PARITY;
          else              buf_rd_en  = 1'b1;
        end
      end
      PARITY: begin
        if (!busy) state_next = GAP;
      end
      GAP: begin
        if (gap_reg == GAP_W'(IFG - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    cmd_fire  = cmd_valid && cmd_ready;
    pl_fire   = pl_valid && pl_ready;
    buf_clear = cmd_fire && cmd_legal;
  end

  // Datapath: command latch, parity accumulation, output byte and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      len_reg       <= '0;
      bad_par_reg   <= 1'b0;
      acc_reg       <= '0;
      pkt_valid_reg <= 1'b0;
      pkt_data_reg  <= '0;
      cmd_err_reg   <= 1'b0;
      tx_done_reg   <= 1'b0;
      count_reg     <= '0;
      gap_reg       <= '0;
    end else begin
      cmd_err_reg <= cmd_fire && !cmd_legal;
      tx_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_fire && cmd_legal) begin
            addr_reg    <= cmd_addr;
            len_reg     <= cmd_len;
            bad_par_reg <= cmd_bad_par;
            acc_reg     <= hdr_pack(cmd_len, cmd_addr);
          end
        end
        LOAD: begin
          if (pl_fire) begin
            acc_reg <= acc_reg ^ pl_data;
            if (last_load) begin
              pkt_data_reg  <= hdr_pack(len_reg, addr_reg);
              pkt_valid_reg <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (!busy) pkt_data_reg <= buf_rd_data;
        end
        PAYLOAD: begin
          if (!busy) begin
            if (last_payload) begin
              pkt_data_reg  <= bad_par_reg ? ~acc_reg : acc_reg;
              pkt_valid_reg <= 1'b0;
            end else begin
              pkt_data_reg  <= buf_rd_data;
            end
          end
        end
        PARITY: begin
          gap_reg <= '0;
          if (!busy) begin
            tx_done_reg  <= 1'b1;
            count_reg    <= count_reg + 1'b1;
            pkt_data_reg <= '0;
          end
        end
        GAP: begin
          gap_reg <= gap_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_err   = cmd_err_reg;
  assign pkt_valid = pkt_valid_reg;
  assign pkt_data  = pkt_data_reg;
  assign tx_done   = tx_done_reg;
  assign pkt_count = count_reg;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with hand-computed header/parity values.
module tb_router_pkt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        cmd_bad_par;
  logic        cmd_err;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  pkt_data;
  logic        tx_done;
  logic [15:0] pkt_count;

  int checks = 0;
  int passed = 0;
  logic [7:0] pl_mem [64];

  always #5 clk = ~clk;

  router_pkt_tx #(.IFG(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_bad_par (cmd_bad_par),
    .cmd_err     (cmd_err),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .pl_data     (pl_data),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .tx_done     (tx_done),
    .pkt_count   (pkt_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sends one packet from pl_mem and checks every wire byte, the done pulse,
  // the counter and the inter-frame gap. stall_idx selects the wire byte
  // (0 = header) that is held under busy for stall_n cycles.
  task automatic run_pkt(input string name, input logic [1:0] a, input logic [5:0] l,
                         input logic bp, input logic [7:0] hdr, input logic [7:0] par,
                         input int stall_idx, input int stall_n, input logic [15:0] cnt);
    logic [7:0] e;
    int n;
    n = int'(l);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_bad_par = bp;
    tick;
    cmd_valid = 1'b0;
    check("pl_ready_load", pl_ready, 1);
    check("pkt_valid_load", pkt_valid, 0);
    for (int i = 0; i < n; i++) begin
      pl_valid = 1'b1; pl_data = pl_mem[i];
      tick;
    end
    pl_valid = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      e = (k == 0) ? hdr : (k <= n) ? pl_mem[k-1] : par;
      check("wire_data", pkt_data, e);
      check("wire_valid", pkt_valid, (k <= n) ? 1 : 0);
      if (k == stall_idx) begin
        for (int s = 0; s < stall_n; s++) begin
          busy = 1'b1;
          tick;
          check("hold_data", pkt_data, e);
          check("hold_valid", pkt_valid, (k <= n) ? 1 : 0);
        end
      end
      busy = 1'b0;
      tick;
      if (k <= n) check("tx_done_early", tx_done, 0);
    end
    check("tx_done", tx_done, 1);
    check("pkt_count", pkt_count, cnt);
    check("data_after_par", pkt_data, 0);
    check("valid_after_par", pkt_valid, 0);
    check("gap_ready0", cmd_ready, 0);
    for (int g = 0; g < 2; g++) begin
      tick;
      check("gap_ready", cmd_ready, 0);
      check("tx_done_pulse", tx_done, 0);
    end
    tick;
    check("ready_after_gap", cmd_ready, 1);
    $display("pkt %s addr=%0d len=%0d hdr=%02h par=%02h count=%0d", name, a, l, hdr, par, pkt_count);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_bad_par = 1'b0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
    tick;
    tick;
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    #1;
    check("idle_ready", cmd_ready, 1);
    $display("reset released");

    // Basic packet: header 0D, parity 0D^A1^B2^C3 = DD.
    pl_mem[0] = 8'hA1; pl_mem[1] = 8'hB2; pl_mem[2] = 8'hC3;
    run_pkt("basic", 2'd1, 6'd3, 1'b0, 8'h0D, 8'hDD, -1, 0, 16'd1);

    // Same packet with A1 held for two busy cycles.
    run_pkt("busy", 2'd1, 6'd3, 1'b0, 8'h0D, 8'hDD, 1, 2, 16'd2);

    // Illegal address.
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 6'd5; cmd_bad_par = 1'b0;
    check("err_addr_ready", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    check("err_addr_pulse", cmd_err, 1);
    check("err_addr_pl_ready", pl_ready, 0);
    check("err_addr_valid", pkt_valid, 0);
    tick;
    check("err_addr_pulse_end", cmd_err, 0);
    check("err_addr_idle", cmd_ready, 1);
    $display("cmd addr=3 len=5 rejected");

    // Zero length.
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd0;
    tick;
    cmd_valid = 1'b0;
    check("err_len_pulse", cmd_err, 1);
    check("err_len_pl_ready", pl_ready, 0);
    check("err_len_valid", pkt_valid, 0);
    tick;
    check("err_len_pulse_end", cmd_err, 0);
    $display("cmd addr=0 len=0 rejected");

    // Injected parity error: ~DD = 22.
    run_pkt("bad_par", 2'd1, 6'd3, 1'b1, 8'h0D, 8'h22, -1, 0, 16'd3);

    // Maximum length: header FE, XOR(00..3E) = 3F, parity FE^3F = C1.
    for (int i = 0; i < 63; i++) pl_mem[i] = 8'(i);
    run_pkt("max_len", 2'd2, 6'd63, 1'b0, 8'hFE, 8'hC1, -1, 0, 16'd4);

    // Reset while the second payload byte is on the wire.
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33; pl_mem[3] = 8'h44;
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd4; cmd_bad_par = 1'b0;
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pl_valid = 1'b1; pl_data = pl_mem[i];
      tick;
    end
    pl_valid = 1'b0;
    check("abort_hdr", pkt_data, 8'h10);
    tick;
    check("abort_b0", pkt_data, 8'h11);
    tick;
    check("abort_b1", pkt_data, 8'h22);
    rst = 1'b1;
    tick;
    check("abort_valid", pkt_valid, 0);
    check("abort_count", pkt_count, 0);
    check("abort_ready_rst", cmd_ready, 0);
    check("abort_tx_done", tx_done, 0);
    rst = 1'b0;
    #1;
    $display("reset mid-packet, count=%0d", pkt_count);

    // Clean packet after abort: header 08, parity 08^5A^A5 = F7.
    pl_mem[0] = 8'h5A; pl_mem[1] = 8'hA5;
    run_pkt("after_rst", 2'd0, 6'd2, 1'b0, 8'h08, 8'hF7, -1, 0, 16'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
